// File: rtl/hdmi_pll_seq.sv
`timescale 1ns/1ps
// Purpose: HDMI rPLL mode sequencer (RESET, IDSEL/FBDSEL/ODSEL, LOCK qualification, pixel reset) in the clkin domain.
// Latency: accept at edge N -> selects/pll_reset at N+1; lock_s rise -> locked after LOCK_STABLE_CYCLES+1 edges.
// Backpressure: mode_req_ready only in LOCKED/FAIL, no queuing. Option HDMI_PLL_SEQ_AUTORECOVER_EN: relock on lock loss instead of FAIL.
module hdmi_pll_seq #(
  parameter int NUM_MODES = 4,
  parameter logic [18*NUM_MODES-1:0] MODE_TABLE = '0,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES = 3,
  localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic [MW-1:0] mode_req,
  input  logic          mode_req_valid,
  output logic          mode_req_ready,
  input  logic          pll_lock,
  output logic          pll_reset,
  output logic [5:0]    idsel,
  output logic [5:0]    fbdsel,
  output logic [5:0]    odsel,
  output logic [MW-1:0] cur_mode,
  output logic          locked,
  output logic          pix_rst,
  output logic          fail,
  output logic          bad_req,
  output logic [RW-1:0] retry_cnt
);

  localparam int HW = $clog2(RESET_HOLD_CYCLES);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT,
    S_STABLE,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [SW-1:0]   stable_cnt_q, stable_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [17:0]     sel_q, sel_d;
  logic [MW-1:0]   cur_mode_q, cur_mode_d;
  logic            bad_req_q, bad_req_d;
  logic            lock_meta_q, lock_meta_d;
  logic            lock_s_q, lock_s_d;

  logic            req_fire;
  logic            req_in_range;
  logic            timeout;
  logic            retry_left;

  // Table entry m lives at bits [18m+17:18m] as {idsel, fbdsel, odsel}.
  function automatic logic [17:0] table_entry(input logic [MW-1:0] m);
    return MODE_TABLE[18*int'(m) +: 18];
  endfunction

  // Moore outputs decoded straight from the state register.
  assign mode_req_ready = (state_q == S_LOCKED) || (state_q == S_FAIL);
  assign pll_reset      = (state_q == S_HOLD) || (state_q == S_FAIL);
  assign locked         = (state_q == S_LOCKED);
  assign pix_rst        = (state_q != S_LOCKED);
  assign fail           = (state_q == S_FAIL);
  assign bad_req        = bad_req_q;
  assign retry_cnt      = retry_q;
  assign cur_mode       = cur_mode_q;
  assign idsel          = sel_q[17:12];
  assign fbdsel         = sel_q[11:6];
  assign odsel          = sel_q[5:0];

  assign req_fire     = mode_req_valid && mode_req_ready;
  assign req_in_range = 32'(mode_req) < 32'(NUM_MODES);
  assign timeout      = (to_cnt_q >= TO_LAST);
  assign retry_left   = 32'(retry_q) < 32'(MAX_RETRIES);

  // Next-state, counters and request handling; a valid in-range request overrides the state walk.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    stable_cnt_d = '0;
    to_cnt_d     = to_cnt_q;
    retry_d      = retry_q;
    sel_d        = sel_q;
    cur_mode_d   = cur_mode_q;
    bad_req_d    = 1'b0;
    lock_meta_d  = pll_lock;
    lock_s_d     = lock_meta_q;

    case (state_q)
      S_HOLD: begin
        to_cnt_d = '0;
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          state_d    = S_WAIT;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      S_WAIT: begin
        to_cnt_d = to_cnt_q + TW'(1);
        if (timeout) begin
          if (retry_left) begin
            retry_d    = retry_q + RW'(1);
            hold_cnt_d = '0;
            state_d    = S_HOLD;
          end else begin
            state_d = S_FAIL;
          end
        end else if (lock_s_q) begin
          state_d = S_STABLE;
        end
      end
      S_STABLE: begin
        to_cnt_d = to_cnt_q + TW'(1);
        if (lock_s_q && (stable_cnt_q == STABLE_LAST)) begin
          state_d = S_LOCKED;
        end else if (timeout) begin
          if (retry_left) begin
            retry_d    = retry_q + RW'(1);
            hold_cnt_d = '0;
            state_d    = S_HOLD;
          end else begin
            state_d = S_FAIL;
          end
        end else if (!lock_s_q) begin
          // Glitch: restart the stability window but keep the timeout running.
          state_d = S_WAIT;
        end else begin
          stable_cnt_d = stable_cnt_q + SW'(1);
        end
      end
      S_LOCKED: begin
        to_cnt_d = '0;
        if (!lock_s_q) begin
`ifdef HDMI_PLL_SEQ_AUTORECOVER_EN
          state_d = S_WAIT;
`else
          state_d = S_FAIL;
`endif
        end
      end
      S_FAIL: begin
        to_cnt_d = '0;
      end
      default: begin
        state_d  = S_HOLD;
        to_cnt_d = '0;
      end
    endcase

    if (req_fire) begin
      if (req_in_range) begin
        state_d      = S_HOLD;
        hold_cnt_d   = '0;
        stable_cnt_d = '0;
        to_cnt_d     = '0;
        retry_d      = '0;
        sel_d        = table_entry(mode_req);
        cur_mode_d   = mode_req;
      end else begin
        bad_req_d = 1'b1;
      end
    end
  end

  // State, counters, latched selects and the two-flop lock synchronizer.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q      <= S_HOLD;
      hold_cnt_q   <= '0;
      stable_cnt_q <= '0;
      to_cnt_q     <= '0;
      retry_q      <= '0;
      sel_q        <= MODE_TABLE[17:0];
      cur_mode_q   <= '0;
      bad_req_q    <= 1'b0;
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      to_cnt_q     <= to_cnt_d;
      retry_q      <= retry_d;
      sel_q        <= sel_d;
      cur_mode_q   <= cur_mode_d;
      bad_req_q    <= bad_req_d;
      lock_meta_q  <= lock_meta_d;
      lock_s_q     <= lock_s_d;
    end
  end

endmodule

// File: tb/tb_hdmi_pll_seq.sv
`timescale 1ns/1ps
// Directed bench for hdmi_pll_seq: boot lock, mode change, timeouts/retries, glitch, lock loss, bad request.
module tb_hdmi_pll_seq;

  localparam logic [71:0] TBL = {6'd10, 6'd11, 6'd12,
                                 6'd7,  6'd8,  6'd9,
                                 6'd4,  6'd5,  6'd6,
                                 6'd1,  6'd2,  6'd3};
  localparam logic [89:0] TBL_B = {6'd13, 6'd14, 6'd15, TBL};

  logic       clk;
  logic       rst;
  logic [1:0] mode_req;
  logic       mode_req_valid;
  logic       mode_req_ready;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] idsel, fbdsel, odsel;
  logic [1:0] cur_mode;
  logic       locked, pix_rst, fail, bad_req;
  logic [1:0] retry_cnt;

  logic [2:0] mode_req_b;
  logic       mode_req_valid_b;
  logic       mode_req_ready_b;
  logic       pll_lock_b;
  logic       pll_reset_b;
  logic [5:0] idsel_b, fbdsel_b, odsel_b;
  logic [2:0] cur_mode_b;
  logic       locked_b, pix_rst_b, fail_b, bad_req_b;
  logic [1:0] retry_cnt_b;

  int tests = 0;
  int fails = 0;

  hdmi_pll_seq #(
    .NUM_MODES(4), .MODE_TABLE(TBL), .RESET_HOLD_CYCLES(4),
    .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32), .MAX_RETRIES(2)
  ) dut (
    .clkin(clk), .rst(rst), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .mode_req_ready(mode_req_ready), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .idsel(idsel), .fbdsel(fbdsel), .odsel(odsel), .cur_mode(cur_mode),
    .locked(locked), .pix_rst(pix_rst), .fail(fail), .bad_req(bad_req),
    .retry_cnt(retry_cnt)
  );

  hdmi_pll_seq #(
    .NUM_MODES(5), .MODE_TABLE(TBL_B), .RESET_HOLD_CYCLES(4),
    .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32), .MAX_RETRIES(2)
  ) dut_b (
    .clkin(clk), .rst(rst), .mode_req(mode_req_b), .mode_req_valid(mode_req_valid_b),
    .mode_req_ready(mode_req_ready_b), .pll_lock(pll_lock_b), .pll_reset(pll_reset_b),
    .idsel(idsel_b), .fbdsel(fbdsel_b), .odsel(odsel_b), .cur_mode(cur_mode_b),
    .locked(locked_b), .pix_rst(pix_rst_b), .fail(fail_b), .bad_req(bad_req_b),
    .retry_cnt(retry_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts cycles with pll_reset high starting at the current sample; bounded.
  task automatic hold_len(input string tag);
    int c;
    c = 0;
    while (pll_reset && c < 20) begin
      c++;
      step(1);
    end
    check(tag, 32'(c), 32'd4);
  endtask

  // Full relock with lock_s already high: 4 HOLD cycles, 1 WAIT, 8 STABLE.
  task automatic relock(input string tag);
    hold_len({tag, "_hold"});
    step(8);
    check({tag, "_early"}, 32'(locked), 32'd0);
    step(1);
    check({tag, "_locked"}, 32'(locked), 32'd1);
    check({tag, "_pixrst"}, 32'(pix_rst), 32'd0);
    check({tag, "_ready"}, 32'(mode_req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pll_lock = 1'b1;
    mode_req = 2'd0;
    mode_req_valid = 1'b0;
    pll_lock_b = 1'b1;
    mode_req_b = 3'd0;
    mode_req_valid_b = 1'b0;

    // Reset state
    step(3);
    check("rst_pll_reset", 32'(pll_reset), 32'd1);
    check("rst_idsel", 32'(idsel), 32'd1);
    check("rst_fbdsel", 32'(fbdsel), 32'd2);
    check("rst_odsel", 32'(odsel), 32'd3);
    check("rst_cur_mode", 32'(cur_mode), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_pix_rst", 32'(pix_rst), 32'd1);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_ready", 32'(mode_req_ready), 32'd0);
    check("rst_bad_req", 32'(bad_req), 32'd0);
    check("rst_retry", 32'(retry_cnt), 32'd0);

    // Boot lock with pll_lock tied high
    rst = 1'b0;
    relock("boot");
    check("boot_idsel", 32'(idsel), 32'd1);
    check("boot_odsel", 32'(odsel), 32'd3);

    // Mode change to 2
    mode_req = 2'd2;
    mode_req_valid = 1'b1;
    step(1);
    mode_req_valid = 1'b0;
    check("m2_idsel", 32'(idsel), 32'd7);
    check("m2_fbdsel", 32'(fbdsel), 32'd8);
    check("m2_odsel", 32'(odsel), 32'd9);
    check("m2_cur_mode", 32'(cur_mode), 32'd2);
    check("m2_locked_drop", 32'(locked), 32'd0);
    check("m2_pix_rst", 32'(pix_rst), 32'd1);
    check("m2_ready", 32'(mode_req_ready), 32'd0);
    relock("m2");

    // Timeouts and retries with pll_lock held low
    pll_lock = 1'b0;
    mode_req = 2'd1;
    mode_req_valid = 1'b1;
    step(1);
    mode_req_valid = 1'b0;
    check("to_cur_mode", 32'(cur_mode), 32'd1);
    check("to_idsel", 32'(idsel), 32'd4);
    hold_len("to0_hold");
    step(1);
    mode_req = 2'd3;
    mode_req_valid = 1'b1;
    step(1);
    mode_req_valid = 1'b0;
    check("ignored_req_cur_mode", 32'(cur_mode), 32'd1);
    check("ignored_req_pll_reset", 32'(pll_reset), 32'd0);
    step(29);
    check("to1_pre_retry", 32'(retry_cnt), 32'd0);
    check("to1_pre_reset", 32'(pll_reset), 32'd0);
    step(1);
    check("to1_retry", 32'(retry_cnt), 32'd1);
    check("to1_reset", 32'(pll_reset), 32'd1);
    hold_len("to1_hold");
    step(31);
    check("to2_pre_retry", 32'(retry_cnt), 32'd1);
    check("to2_pre_reset", 32'(pll_reset), 32'd0);
    step(1);
    check("to2_retry", 32'(retry_cnt), 32'd2);
    check("to2_reset", 32'(pll_reset), 32'd1);
    hold_len("to2_hold");
    step(31);
    check("to3_pre_fail", 32'(fail), 32'd0);
    step(1);
    check("to3_fail", 32'(fail), 32'd1);
    check("to3_ready", 32'(mode_req_ready), 32'd1);
    check("to3_retry", 32'(retry_cnt), 32'd2);
    check("to3_pix_rst", 32'(pix_rst), 32'd1);
    check("to3_pll_reset", 32'(pll_reset), 32'd1);

    // New request clears fail
    pll_lock = 1'b1;
    mode_req = 2'd3;
    mode_req_valid = 1'b1;
    step(1);
    mode_req_valid = 1'b0;
    check("clr_fail", 32'(fail), 32'd0);
    check("clr_retry", 32'(retry_cnt), 32'd0);
    check("clr_cur_mode", 32'(cur_mode), 32'd3);
    check("clr_idsel", 32'(idsel), 32'd10);
    check("clr_odsel", 32'(odsel), 32'd12);
    relock("m3");

    // One-cycle lock glitch at stable count 5
    mode_req = 2'd0;
    mode_req_valid = 1'b1;
    step(1);
    mode_req_valid = 1'b0;
    hold_len("gl_hold");
    step(4);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(4);
    check("gl_no_early_lock", 32'(locked), 32'd0);
    step(6);
    check("gl_still_unlocked", 32'(locked), 32'd0);
    step(1);
    check("gl_locked", 32'(locked), 32'd1);
    check("gl_idsel", 32'(idsel), 32'd1);

    // Lock loss in LOCKED
    pll_lock = 1'b0;
    step(2);
    check("ll_still_locked", 32'(locked), 32'd1);
    step(1);
    check("ll_locked", 32'(locked), 32'd0);
    check("ll_pix_rst", 32'(pix_rst), 32'd1);
`ifdef HDMI_PLL_SEQ_AUTORECOVER_EN
    check("ll_fail", 32'(fail), 32'd0);
    check("ll_pll_reset", 32'(pll_reset), 32'd0);
    pll_lock = 1'b1;
    step(10);
    check("ar_early", 32'(locked), 32'd0);
    step(1);
    check("ar_locked", 32'(locked), 32'd1);
    check("ar_fail", 32'(fail), 32'd0);
    check("ar_retry", 32'(retry_cnt), 32'd0);
`else
    check("ll_fail", 32'(fail), 32'd1);
    check("ll_ready", 32'(mode_req_ready), 32'd1);
    check("ll_pll_reset", 32'(pll_reset), 32'd1);
    pll_lock = 1'b1;
    mode_req = 2'd0;
    mode_req_valid = 1'b1;
    step(1);
    mode_req_valid = 1'b0;
    check("rec_fail", 32'(fail), 32'd0);
    relock("rec");
`endif

    // Out-of-range request on the 5-mode instance
    check("b_locked", 32'(locked_b), 32'd1);
    check("b_ready", 32'(mode_req_ready_b), 32'd1);
    mode_req_b = 3'd5;
    mode_req_valid_b = 1'b1;
    step(1);
    mode_req_valid_b = 1'b0;
    check("bad_pulse", 32'(bad_req_b), 32'd1);
    check("bad_cur_mode", 32'(cur_mode_b), 32'd0);
    check("bad_idsel", 32'(idsel_b), 32'd1);
    check("bad_fbdsel", 32'(fbdsel_b), 32'd2);
    check("bad_odsel", 32'(odsel_b), 32'd3);
    check("bad_locked", 32'(locked_b), 32'd1);
    step(1);
    check("bad_pulse_end", 32'(bad_req_b), 32'd0);
    check("bad_locked_after", 32'(locked_b), 32'd1);
    mode_req_b = 3'd4;
    mode_req_valid_b = 1'b1;
    step(1);
    mode_req_valid_b = 1'b0;
    check("b4_cur_mode", 32'(cur_mode_b), 32'd4);
    check("b4_idsel", 32'(idsel_b), 32'd13);
    check("b4_odsel", 32'(odsel_b), 32'd15);
    check("b4_bad_req", 32'(bad_req_b), 32'd0);
    check("b4_pll_reset", 32'(pll_reset_b), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
